// File: rtl/pal_cfg_pkg.sv
// Shared types for the PAL configuration loader: FSM state encoding and
// beat-counter sizing helper.
package pal_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        DRAIN  = 3'd2,
        COMMIT = 3'd3,
        FAIL   = 3'd4
    } pal_cfg_state_e;

    // Counter must be able to hold BEATS itself so that it can saturate there.
    function automatic int cnt_width(input int beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/pal_cfg_beat_counter.sv
// Beat counter for the configuration loader; saturates at BEATS and flags the
// beat that would complete a full word.
module pal_cfg_beat_counter
    import pal_cfg_pkg::*;
#(
    parameter int BEATS = 8
) (
    input  logic clk,
    input  logic res,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_end_o
);

    localparam int CW = cnt_width(BEATS);
    localparam logic [CW:0] BEATS_W = (CW + 1)'(BEATS);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != BEATS_W[CW-1:0])) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_end_o = (({1'b0, cnt_q} + (CW + 1)'(1)) == BEATS_W);

endmodule

// File: rtl/pal_cfg_loader.sv
// Framed configuration loader: shadow shift register committed atomically to
// the active word on an exact-length frame. Optional macro PAL_CFG_PARITY_EN.
module pal_cfg_loader
    import pal_cfg_pkg::*;
#(
    parameter int LEN   = 8,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             cfg_valid,
    input  logic [LANES-1:0] cfg_data,
    input  logic             cfg_last,
`ifdef PAL_CFG_PARITY_EN
    input  logic             cfg_parity,
`endif
    input  logic             en,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN-1:0]   ff_chain
);

    localparam int BEATS = LEN / LANES;

    generate
        if ((LEN % LANES) != 0) begin : g_len_check
            $error("pal_cfg_loader: LEN must be a multiple of LANES");
        end
    endgenerate

    pal_cfg_state_e state_q, state_d;
    logic [LEN-1:0] shadow_q, shadow_d;
    logic [LEN-1:0] active_q, active_d;
    logic [LEN-1:0] shadow_shift;
    logic           accept, in_load, at_end, par_ok;
    logic           cnt_inc, cnt_clr;

    assign in_load = (state_q == IDLE) || (state_q == SHIFT);
    assign ready   = in_load || (state_q == DRAIN);
    assign busy    = (state_q == SHIFT) || (state_q == DRAIN);
    assign done    = (state_q == COMMIT);
    assign err     = (state_q == FAIL);
    assign accept  = cfg_valid & ready;

    generate
        if (LEN == LANES) begin : g_shift_full
            assign shadow_shift = cfg_data;
        end else begin : g_shift_part
            assign shadow_shift = {shadow_q[LEN-LANES-1:0], cfg_data};
        end
    endgenerate

`ifdef PAL_CFG_PARITY_EN
    // Running XOR covers only bits that actually land in the shadow.
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if ((state_q == COMMIT) || (state_q == FAIL)) begin
            par_d = 1'b0;
        end else if (accept && in_load) begin
            par_d = par_q ^ (^cfg_data);
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_ok = ((par_q ^ (^cfg_data)) == cfg_parity);
`else
    assign par_ok = 1'b1;
`endif

    pal_cfg_beat_counter #(
        .BEATS (BEATS)
    ) u_cnt (
        .clk      (clk),
        .res      (res),
        .inc_i    (cnt_inc),
        .clr_i    (cnt_clr),
        .at_end_o (at_end)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            IDLE, SHIFT: begin
                if (accept) begin
                    shadow_d = shadow_shift;
                    cnt_inc  = 1'b1;
                    if (cfg_last) begin
                        state_d = (at_end && par_ok) ? COMMIT : FAIL;
                    end else if (at_end) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            DRAIN: begin
                // Frame already overlong: keep the shadow, only track the tail.
                if (accept) begin
                    cnt_inc = 1'b1;
                    if (cfg_last) begin
                        state_d = FAIL;
                    end
                end
            end
            COMMIT: begin
                active_d = shadow_q;
                cnt_clr  = 1'b1;
                state_d  = IDLE;
            end
            FAIL: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign ff_chain = en ? active_q : '0;

endmodule
